// File: rtl/bird_datapath.sv
// Bird datapath: holds the bird's top row, applies fall/flap physics and
// streams the 4x4 sprite to the VGA adapter one pixel per cycle.
//
// engine  | meaning
// S_IDLE  | waiting for a new command code from the control FSM
// S_SWEEP | 16-cycle erase/draw of the sprite, row-major from top-left
// S_CALC  | one-cycle bird_y update for FALL or FLAP
// S_DONE  | one-cycle completion pulse on flag
module bird_datapath #(
    parameter logic [7:0] X_POS       = 8'd20,
    parameter int         BIRD_W      = 4,
    parameter int         BIRD_H      = 4,
    parameter logic [6:0] Y_INIT      = 7'd56,
    parameter logic [6:0] Y_MAX       = 7'd115,
    parameter logic [6:0] GRAVITY     = 7'd1,
    parameter logic [6:0] FLAP        = 7'd6,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter logic [2:0] BIRD_COLOUR = 3'b110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] state,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       flag,
    output logic [6:0] bird_y,
    output logic       hit_floor
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_CALC, S_DONE} eng_t;

    localparam logic [3:0] CMD_ERASE = 4'd1;
    localparam logic [3:0] CMD_FALL  = 4'd2;
    localparam logic [3:0] CMD_FLAP  = 4'd3;
    localparam logic [3:0] CMD_DRAW  = 4'd4;
    localparam logic [3:0] C_LAST    = 4'(BIRD_W * BIRD_H - 1);

    eng_t       eng, eng_nxt;
    logic [3:0] last_cmd;
    logic [3:0] cmd;
    logic [3:0] c;
    logic       accept;
    logic [7:0] px_x, x_hold;
    logic [6:0] px_y, y_hold;
    logic [2:0] px_col, col_hold;
    logic [7:0] fall_sum;
    logic [6:0] fall_y, flap_y, y_new;

    assign accept = (eng == S_IDLE) && (state >= CMD_ERASE) && (state <= CMD_DRAW)
                    && (state != last_cmd);

    assign px_x   = X_POS + {6'd0, c[1:0]};
    assign px_y   = bird_y + {5'd0, c[3:2]};
    assign px_col = (cmd == CMD_ERASE) ? BG_COLOUR : BIRD_COLOUR;

    // Sum is one bit wider than bird_y so the floor clamp sees any overflow.
    assign fall_sum = {1'b0, bird_y} + {1'b0, GRAVITY};
    assign fall_y   = (fall_sum > {1'b0, Y_MAX}) ? Y_MAX : fall_sum[6:0];
    assign flap_y   = (bird_y < FLAP) ? 7'd0 : bird_y - FLAP;
    assign y_new    = (cmd == CMD_FLAP) ? flap_y : fall_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) eng <= S_IDLE;
        else       eng <= eng_nxt;
    end

    always_comb begin
        eng_nxt = eng;
        case (eng)
            S_IDLE: begin
                if (accept)
                    eng_nxt = (state == CMD_ERASE || state == CMD_DRAW) ? S_SWEEP : S_CALC;
            end
            S_SWEEP: if (c == C_LAST) eng_nxt = S_DONE;
            S_CALC:  eng_nxt = S_DONE;
            S_DONE:  eng_nxt = S_IDLE;
            default: eng_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        plot   = (eng == S_SWEEP);
        flag   = (eng == S_DONE);
        x_out  = plot ? px_x   : x_hold;
        y_out  = plot ? px_y   : y_hold;
        colour = plot ? px_col : col_hold;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_cmd  <= 4'd0;
            cmd       <= 4'd0;
            c         <= 4'd0;
            bird_y    <= Y_INIT;
            hit_floor <= 1'b0;
            x_hold    <= 8'd0;
            y_hold    <= 7'd0;
            col_hold  <= 3'd0;
        end else begin
            if (accept) begin
                cmd      <= state;
                last_cmd <= state;
            end else if (state == 4'd0) begin
                last_cmd <= 4'd0;
            end

            c <= (eng == S_SWEEP) ? c + 4'd1 : 4'd0;

            if (eng == S_SWEEP) begin
                x_hold   <= px_x;
                y_hold   <= px_y;
                col_hold <= px_col;
            end

            if (eng == S_CALC) begin
                bird_y <= y_new;
                if (y_new == Y_MAX) hit_floor <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bird_datapath.sv
// Directed bench for bird_datapath: sprite sweeps, physics clamps, busy
// behaviour and asynchronous reset abort.
module tb_bird_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot, flag, hit_floor;
    logic [6:0] bird_y;

    int tests = 0;
    int failures = 0;

    bird_datapath dut (
        .clk(clk), .reset(reset), .state(state), .x_out(x_out), .y_out(y_out),
        .colour(colour), .plot(plot), .flag(flag), .bird_y(bird_y),
        .hit_floor(hit_floor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        state = 4'd0;
        repeat (n) step();
    endtask

    // Issue a command from IDLE, check every plotted pixel, the flag latency
    // counted from the accept edge, and that flag drops the cycle after.
    task automatic run_cmd(input logic [3:0] cmd, input logic [2:0] col,
                           input logic [6:0] y0, input int exp_lat, input int exp_plots);
        int n, np, lat;
        n = 0; np = 0; lat = 0;
        state = cmd;
        while (lat == 0 && n < 40) begin
            step();
            n++;
            if (plot) begin
                chk("pix_x", x_out, 20 + np % 4);
                chk("pix_y", y_out, y0 + np / 4);
                chk("pix_colour", colour, col);
                np++;
            end
            if (flag) lat = n;
        end
        chk("flag_latency", lat, exp_lat);
        chk("plot_count", np, exp_plots);
        step();
        chk("flag_one_cycle", flag, 0);
        chk("plot_after_done", plot, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, np, lat1, lat2;
        reset = 1'b1;
        state = 4'd0;
        repeat (3) step();
        chk("rst_bird_y", bird_y, 56);
        chk("rst_plot", plot, 0);
        chk("rst_flag", flag, 0);
        chk("rst_hit_floor", hit_floor, 0);
        chk("rst_x_out", x_out, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_colour", colour, 0);
        reset = 1'b0;
        step();

        // DRAW after reset, then hold state=4: no retrigger, outputs hold.
        run_cmd(4'd4, 3'b110, 7'd56, 17, 16);
        np = 0; n = 0;
        repeat (5) begin
            step();
            if (plot) np++;
            if (flag) n++;
        end
        chk("held_no_plot", np, 0);
        chk("held_no_flag", n, 0);
        chk("hold_x_out", x_out, 23);
        chk("hold_y_out", y_out, 59);
        chk("hold_colour", colour, 3'b110);

        // ERASE, FALL, DRAW back to back.
        run_cmd(4'd1, 3'b000, 7'd56, 17, 16);
        run_cmd(4'd2, 3'b000, 7'd0, 2, 0);
        chk("fall_bird_y", bird_y, 57);
        run_cmd(4'd4, 3'b110, 7'd57, 17, 16);

        // DRAW interrupted by FALL at pixel 5: sweep unchanged, FALL afterwards.
        idle(1);
        state = 4'd4;
        n = 0; np = 0; lat1 = 0; lat2 = 0;
        while (n < 22) begin
            step();
            n++;
            if (plot) begin
                chk("int_pix_x", x_out, 20 + np % 4);
                chk("int_pix_y", y_out, 57 + np / 4);
                chk("int_pix_colour", colour, 3'b110);
                chk("int_bird_y_frozen", bird_y, 57);
                np++;
                if (np == 6) state = 4'd2;
            end
            if (flag && lat1 == 0) lat1 = n;
            else if (flag && lat2 == 0) lat2 = n;
            if (n == 19) chk("int_bird_y_before_calc", bird_y, 57);
            if (n == 20) chk("int_bird_y_after_calc", bird_y, 58);
        end
        chk("int_plot_count", np, 16);
        chk("int_draw_latency", lat1, 17);
        chk("int_fall_flag_cycle", lat2, 20);
        idle(1);

        // FLAP down to the top clamp, then bird_y=3 flaps to 0.
        for (int i = 0; i < 9; i++) begin
            run_cmd(4'd3, 3'b000, 7'd0, 2, 0);
            idle(1);
        end
        chk("flap_series_y", bird_y, 4);
        run_cmd(4'd3, 3'b000, 7'd0, 2, 0);
        chk("flap_clamp_from_4", bird_y, 0);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            run_cmd(4'd2, 3'b000, 7'd0, 2, 0);
            idle(1);
        end
        chk("fall_to_3", bird_y, 3);
        run_cmd(4'd3, 3'b000, 7'd0, 2, 0);
        chk("flap_clamp_from_3", bird_y, 0);
        idle(1);

        // 59 FALLs from Y_INIT reach the floor.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 59; i++) begin
            run_cmd(4'd2, 3'b000, 7'd0, 2, 0);
            idle(1);
            if (i == 57) begin
                chk("floor_minus1_y", bird_y, 114);
                chk("floor_minus1_hit", hit_floor, 0);
            end
        end
        chk("floor_y", bird_y, 115);
        chk("floor_hit", hit_floor, 1);
        run_cmd(4'd2, 3'b000, 7'd0, 2, 0);
        chk("floor_saturate", bird_y, 115);
        run_cmd(4'd3, 3'b000, 7'd0, 2, 0);
        chk("flap_off_floor", bird_y, 109);
        chk("hit_floor_sticky", hit_floor, 1);
        idle(1);

        // Reset at pixel 8 of a DRAW aborts; next DRAW restarts at pixel 0.
        state = 4'd4;
        n = 0; np = 0;
        while (np < 9 && n < 40) begin
            step();
            n++;
            if (plot) np++;
        end
        chk("abort_reached_pixel8", np, 9);
        reset = 1'b1;
        #1;
        chk("abort_plot", plot, 0);
        chk("abort_flag", flag, 0);
        chk("abort_bird_y", bird_y, 56);
        chk("abort_hit_floor", hit_floor, 0);
        chk("abort_x_out", x_out, 0);
        state = 4'd0;
        n = 0;
        repeat (3) begin
            step();
            if (flag || plot) n++;
        end
        chk("abort_quiet", n, 0);
        reset = 1'b0;
        step();
        run_cmd(4'd4, 3'b110, 7'd56, 17, 16);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/bird_datapath.md
Name: bird_datapath

Overview:
Datapath stage directly downstream of the game control FSM. Consumes the 4-bit state code driven by the controller, and keeps the bird's vertical position and its fall/flap physics. Drives the 160x120 VGA adapter one pixel per cycle to erase and redraw the bird sprite. Returns a one-cycle completion pulse (flag) that the bird controller uses to advance its FSM.

Parameters:
X_POS, 20, fixed bird column (left edge), pixels
BIRD_W, 4, sprite width; must be 4
BIRD_H, 4, sprite height; must be 4
Y_INIT, 56, bird top row after reset
Y_MAX, 115, lowest legal top row (floor)
GRAVITY, 1, rows added per FALL command
FLAP, 6, rows subtracted per FLAP command
BG_COLOUR, 3'b000, erase colour
BIRD_COLOUR, 3'b110, draw colour

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
state  in  4  command code from control FSM
x_out  out  8  pixel x to VGA adapter
y_out  out  7  pixel y to VGA adapter
colour  out  3  pixel colour
plot  out  1  pixel write enable
flag  out  1  one-cycle command-complete pulse
bird_y  out  7  current bird top row
hit_floor  out  1  bird at Y_MAX (sticky until reset)

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-high. While reset is high: bird_y=Y_INIT; x_out=0; y_out=0; colour=0; plot=0; flag=0; hit_floor=0; engine IDLE; last_cmd=0.
- Command codes: 0 IDLE, 1 ERASE, 2 FALL, 3 FLAP, 4 DRAW. Codes 5-15 are treated as IDLE and are never accepted.
- Accept rule: a command is accepted when the engine is IDLE, state is in 1..4, and state != last_cmd.
  - On accept, last_cmd<=state.
  - A state of 0 clears last_cmd to 0, so the same command may be issued again.
  - A held state never retriggers.
- Internal FSM: IDLE -> SWEEP (ERASE/DRAW) or CALC (FALL/FLAP) -> DONE -> IDLE.
- SWEEP:
  - A 4-bit counter c starts at 0 on the cycle after accept.
  - For 16 consecutive cycles: plot=1, x_out=X_POS+c[1:0], y_out=bird_y+c[3:2], colour=BG_COLOUR (ERASE) or BIRD_COLOUR (DRAW).
  - Pixel order is row-major, top-left first.
  - bird_y is frozen during SWEEP.
- CALC (one cycle):
  - FALL: bird_y <= min(bird_y+GRAVITY, Y_MAX). The sum is computed 8 bits wide so it cannot wrap.
  - FLAP: bird_y <= (bird_y < FLAP) ? 0 : bird_y-FLAP. Clamp at 0, no underflow.
  - hit_floor <= 1 when the new bird_y == Y_MAX. It stays 1 until reset; a later FLAP does not clear it.
- DONE: flag=1 for exactly one cycle, plot=0, then return to IDLE.
- Latency from the accept edge to the flag pulse:
  - ERASE/DRAW: flag is high in cycle 17 after accept.
  - FALL/FLAP: flag is high in cycle 2 after accept.
- plot is 0 in every cycle outside SWEEP. x_out, y_out and colour hold their last values when plot=0.
- A change of state while busy is ignored. It is re-evaluated in IDLE under the accept rule.
- Reset asserted mid-sweep or mid-calc aborts immediately. No flag is emitted, and all outputs take their reset values.
- bird_y never exceeds Y_MAX, so y_out never exceeds Y_MAX+3 = 118 (< 120).

Test Plan:
- Reset then state=4 -> 16 plot cycles, pixels x 20..23, y 56..59, colour 3'b110, row-major; flag high exactly one cycle, 17 cycles after accept; no further plots while state held at 4.
- state sequence 1,2,4 (each held until flag) -> erase pixels at y 56..59 with colour 0, bird_y becomes 57, draw pixels at y 57..60 with colour 3'b110.
- bird_y=3, state=3 -> bird_y=0 (clamped), flag 2 cycles after accept, plot stays 0.
- 59 FALL commands from Y_INIT, with state=0 between each -> bird_y reaches 115 and saturates; hit_floor=1; a further FALL leaves bird_y=115; a FLAP gives 109 with hit_floor still 1.
- state=4 then switched to 2 at pixel 5 -> sweep completes all 16 pixels unchanged; FALL is accepted only after DONE; bird_y changes only after the sweep.
- reset pulsed at pixel 8 of a DRAW -> plot=0 and flag=0 immediately, bird_y=56; the next DRAW starts again from pixel 0.
